// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared types and defaults for the mux scan sequencer.
//   state_t   : sequencer FSM states (IDLE, SCAN, DONE)
//   sel_width : select width for an N-input mux (log2, minimum 1)
//   DEF_*     : default mux size and derived select/count widths
package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_N_IN  = 64;
    localparam int unsigned DEF_SEL_W = sel_width(DEF_N_IN);
    localparam int unsigned DEF_CNT_W = DEF_SEL_W + 1;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: handshake bundle between the layer controller,
// the sequencer and the downstream consumer.
//   start/count     : scan request and number of inputs to scan
//   slc             : mux select (current index)
//   out_valid/ready : item handshake toward the consumer
//   first/last      : item position markers
//   busy/done       : scan status and completion pulse
//   en_mask         : per-input enable (only with MUX_SEQ_MASK_EN)
// modport master: the sequencer; modport slave: controller/consumer side.
interface mux_scan_sequencer_if
    import mux_seq_pkg::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned SEL_W = DEF_SEL_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic             start;
    logic [CNT_W-1:0] count;
    logic [SEL_W-1:0] slc;
    logic             out_valid;
    logic             out_ready;
    logic             first;
    logic             last;
    logic             busy;
    logic             done;
`ifdef MUX_SEQ_MASK_EN
    logic [N_IN-1:0]  en_mask;
`endif

    modport master (
        input  start,
        input  count,
        input  out_ready,
`ifdef MUX_SEQ_MASK_EN
        input  en_mask,
`endif
        output slc,
        output out_valid,
        output first,
        output last,
        output busy,
        output done
    );

    modport slave (
        output start,
        output count,
        output out_ready,
`ifdef MUX_SEQ_MASK_EN
        output en_mask,
`endif
        input  slc,
        input  out_valid,
        input  first,
        input  last,
        input  busy,
        input  done
    );

endinterface

// File: rtl/mux_seq_next_idx.sv
// mux_seq_next_idx: combinational priority search for the lowest enabled
// index strictly above idx and strictly below limit.
//   mask     : per-index enable
//   idx      : current index (search starts at idx+1)
//   limit    : exclusive upper bound (scan count)
//   next_idx : lowest qualifying index (0 when none)
//   has_next : a qualifying index exists
module mux_seq_next_idx
    import mux_seq_pkg::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned SEL_W = DEF_SEL_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic [N_IN-1:0]  mask,
    input  logic [SEL_W-1:0] idx,
    input  logic [CNT_W-1:0] limit,
    output logic [SEL_W-1:0] next_idx,
    output logic             has_next
);

    always_comb begin
        next_idx = '0;
        has_next = 1'b0;
        for (int unsigned j = 0; j < N_IN; j++) begin
            if (!has_next && mask[j] &&
                (CNT_W'(j) > {1'b0, idx}) && (CNT_W'(j) < limit)) begin
                next_idx = SEL_W'(j);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the select of an external N_IN-input mux so a
// group of lanes is serialized into one valid/ready stream.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mux_scan_sequencer_if.master (start/count in, slc/out_valid/
//         first/last/busy/done out, out_ready in, optional en_mask in)
// Optional feature macro: MUX_SEQ_MASK_EN (skip masked-off indices with no
// bubble cycles; a scan with no enabled index in range behaves as empty).
module mux_scan_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned SEL_W = sel_width(N_IN),
    parameter int unsigned CNT_W = SEL_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_sequencer_if.master  bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] slc_q;
    logic             valid_q;
    logic             first_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] cnt_cl;
    logic             start_empty;
    logic [SEL_W-1:0] start_idx;
    logic             start_last;
    logic [SEL_W-1:0] step_idx;
    logic             step_last;

    always_comb begin
        cnt_cl = (bus.count > CNT_W'(N_IN)) ? CNT_W'(N_IN) : bus.count;
    end

`ifdef MUX_SEQ_MASK_EN
    // Keep a one-ahead pointer (nxt_q) so each step needs only one search:
    // last is simply "no enabled index beyond the next one".
    logic [N_IN-1:0]  mask_q;
    logic [SEL_W-1:0] nxt_q;
    logic             zero_en;
    logic [SEL_W-1:0] f_next;
    logic             f_has;
    logic [SEL_W-1:0] fl_next;
    logic             fl_has;
    logic [SEL_W-1:0] s_next;
    logic             s_has;

    mux_seq_next_idx #(.N_IN(N_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_first (
        .mask     (bus.en_mask),
        .idx      ('0),
        .limit    (cnt_cl),
        .next_idx (f_next),
        .has_next (f_has)
    );

    mux_seq_next_idx #(.N_IN(N_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_first_la (
        .mask     (bus.en_mask),
        .idx      (start_idx),
        .limit    (cnt_cl),
        .next_idx (fl_next),
        .has_next (fl_has)
    );

    mux_seq_next_idx #(.N_IN(N_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_step (
        .mask     (mask_q),
        .idx      (nxt_q),
        .limit    (cnt_q),
        .next_idx (s_next),
        .has_next (s_has)
    );

    always_comb begin
        // The search is strictly above idx, so index 0 is tested separately.
        zero_en     = bus.en_mask[0] && (cnt_cl != '0);
        start_idx   = zero_en ? '0 : f_next;
        start_empty = !(zero_en || f_has);
        start_last  = !fl_has;
        step_idx    = nxt_q;
        step_last   = !s_has;
    end
`else
    always_comb begin
        start_empty = (cnt_cl == '0);
        start_idx   = '0;
        start_last  = (cnt_cl == CNT_W'(1));
        step_idx    = slc_q + SEL_W'(1);
        step_last   = (({1'b0, slc_q} + CNT_W'(2)) == cnt_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt_q   <= '0;
            slc_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MUX_SEQ_MASK_EN
            mask_q  <= '0;
            nxt_q   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    slc_q  <= '0;
                    if (bus.start) begin
                        cnt_q  <= cnt_cl;
                        busy_q <= 1'b1;
`ifdef MUX_SEQ_MASK_EN
                        mask_q <= bus.en_mask;
                        nxt_q  <= fl_next;
`endif
                        if (start_empty) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= SCAN;
                            valid_q <= 1'b1;
                            slc_q   <= start_idx;
                            first_q <= 1'b1;
                            last_q  <= start_last;
                        end
                    end
                end
                SCAN: begin
                    if (bus.out_ready) begin
                        first_q <= 1'b0;
                        if (last_q) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            slc_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            slc_q  <= step_idx;
                            last_q <= step_last;
`ifdef MUX_SEQ_MASK_EN
                            nxt_q  <= s_next;
`endif
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.slc       = slc_q;
        bus.out_valid = valid_q;
        bus.first     = first_q;
        bus.last      = last_q;
        bus.busy      = busy_q;
        bus.done      = done_q;
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: randomized scoreboard bench for mux_scan_sequencer.
// Expected items come from a list-based model of the scan rules; a negedge
// monitor pops and compares every transfer and done pulse.
// Define MUX_SEQ_MASK_EN for both RTL and bench to exercise masking.
module tb_mux_scan_sequencer;
    import mux_seq_pkg::*;

    localparam int unsigned N  = 64;
    localparam int unsigned SW = 6;
    localparam int unsigned CW = 7;

    typedef struct {
        int idx;
        bit first;
        bit last;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_scan_sequencer_if #(.N_IN(N), .SEL_W(SW), .CNT_W(CW)) bus();

    mux_scan_sequencer #(.N_IN(N), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    item_t exp_q[$];
    int    exp_done   = 0;
    int    tests      = 0;
    int    fails      = 0;
    int    ready_mode = 1;   // 0 random, 1 always high, 2 toggle
    bit    tog        = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the enabled indices below min(count, N), in order.
    task automatic push_scan(input int cnt, input logic [N-1:0] m, output int n_items);
        int lim;
        int idxs[$];
        item_t it;
        lim = (cnt > int'(N)) ? int'(N) : cnt;
        for (int i = 0; i < lim; i++)
            if (m[i]) idxs.push_back(i);
        for (int k = 0; k < idxs.size(); k++) begin
            it.idx   = idxs[k];
            it.first = (k == 0);
            it.last  = (k == idxs.size() - 1);
            exp_q.push_back(it);
        end
        exp_done++;
        n_items = idxs.size();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            if (bus.busy === 1'b0) return;
            @(posedge clk); #1;
        end
        tests++; fails++;
        $display("FAIL idle_timeout: got busy=%0d expected 0", bus.busy);
    endtask

    task automatic do_scan(input int cnt, input logic [N-1:0] m_in, input int mode,
                           input bit double_start);
        int n;
        int cyc;
        logic [N-1:0] m;
        m = m_in;
`ifndef MUX_SEQ_MASK_EN
        m = '1;
`endif
        wait_idle();
        ready_mode = mode;
        if (mode == 1) bus.out_ready = 1'b1;
        bus.count = CW'(cnt);
`ifdef MUX_SEQ_MASK_EN
        bus.en_mask = m;
`endif
        bus.start = 1'b1;
        push_scan(cnt, m, n);
        @(posedge clk); #1;
        cyc = 1;
        while (cyc <= 1000) begin
            // Holding start one extra cycle while busy must be ignored,
            // and changed count/mask must not affect the running scan.
            if (cyc == 1 && double_start) begin
                bus.count = CW'(8);
`ifdef MUX_SEQ_MASK_EN
                bus.en_mask = '1;
`endif
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) break;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        if (cyc > 1000) begin
            tests++; fails++;
            $display("FAIL done_timeout: got no done expected done after %0d cycles", n + 1);
        end else if (mode == 1) begin
            check("done_latency", cyc, n + 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_slc"},       bus.slc,       0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_first"},     bus.first,     0);
        check({tag, "_last"},      bus.last,      0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_done"},      bus.done,      0);
    endtask

    // out_ready driver
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       bus.out_ready = 1'b1;
                2: begin tog = ~tog; bus.out_ready = tog; end
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        item_t      it;
        logic [SW-1:0] p_slc = '0;
        logic       p_first = 1'b0;
        logic       p_last  = 1'b0;
        bit         p_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                p_stall = 1'b0;
            end else begin
                check("busy_consistent", bus.busy, bus.out_valid | bus.done);
                if (p_stall) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_slc",   bus.slc,   p_slc);
                    check("hold_first", bus.first, p_first);
                    check("hold_last",  bus.last,  p_last);
                end
                if (bus.out_valid !== 1'b1) begin
                    check("idle_slc_zero", bus.slc, 0);
                    check("idle_first_zero", bus.first, 0);
                    check("idle_last_zero", bus.last, 0);
                end
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_item: got slc=%0d expected no item", bus.slc);
                    end else begin
                        it = exp_q.pop_front();
                        check("item_slc",   bus.slc,   it.idx);
                        check("item_first", bus.first, it.first);
                        check("item_last",  bus.last,  it.last);
                    end
                end
                if (bus.done === 1'b1) begin
                    if (exp_done == 0) begin
                        tests++; fails++;
                        $display("FAIL spurious_done: got done=1 expected 0");
                    end else begin
                        exp_done--;
                        check("done_items_left", exp_q.size(), 0);
                        check("done_valid_low",  bus.out_valid, 0);
                    end
                end
                p_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
                p_slc   = bus.slc;
                p_first = bus.first;
                p_last  = bus.last;
            end
        end
    end

    // Main stimulus
    initial begin
        int          cnt;
        int          mode;
        logic [N-1:0] m;
        bit          dbl;
        int          guard;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.count = '0;
`ifdef MUX_SEQ_MASK_EN
        bus.en_mask = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Directed: basic count=4 at full rate
        do_scan(4, '1, 1, 1'b0);
        // Full-width scan with toggling ready
        do_scan(64, '1, 2, 1'b0);
        // Empty scan
        do_scan(0, '1, 1, 1'b0);
        // Start held during SCAN with count=8 is ignored
        do_scan(5, '1, 1, 1'b1);
        // Oversized count clamps to N
        do_scan(100, '1, 1, 1'b0);
        do_scan(1, '1, 1, 1'b0);

        // Reset in the middle of a count=10 scan at slc=5
        wait_idle();
        ready_mode = 1;
        bus.out_ready = 1'b1;
        begin
            int n;
            push_scan(10, '1, n);
        end
        bus.count = CW'(10);
`ifdef MUX_SEQ_MASK_EN
        bus.en_mask = '1;
`endif
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        guard = 0;
        while (!(bus.out_valid === 1'b1 && bus.slc == SW'(5)) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("reach_slc5", guard < 100, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midscan_reset");
        exp_q.delete();
        exp_done = 0;
        rst = 1'b0;
        do_scan(3, '1, 1, 1'b0);

`ifdef MUX_SEQ_MASK_EN
        do_scan(8, 64'h0000_0000_0000_00A5, 1, 1'b0);
        do_scan(16, '0, 1, 1'b0);
        do_scan(64, 64'h8000_0000_0000_0001, 2, 1'b0);
`endif

        // Randomized scans
        for (int t = 0; t < 40; t++) begin
            cnt  = $urandom_range(0, 70);
            mode = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       m = '1;
                1:       m = {$urandom, $urandom};
                2:       m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                default: m = '0;
            endcase
            dbl = ($urandom_range(0, 3) == 0);
            do_scan(cnt, m, mode, dbl);
        end

        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_done_pending", exp_done, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequencer that drives the select of a shared N_IN-input mux so that a group of datapath lanes (for example, neuron outputs) is serialized into one stream.
- The mux stays combinational and outside this block. Mux output is valid in the same cycle as `slc`.
- Sits between the layer controller, which issues `start`/`count`, and the downstream consumer, which provides `out_ready`.

Parameters:
- N_IN, 64, number of mux inputs. Must be a power of 2, at least 2.
- SEL_W, 6, select width; equals log2(N_IN).
- CNT_W, 7, width of `count`; equals SEL_W+1, so N_IN itself is representable.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan. Sampled only in IDLE.
- count  in  CNT_W  number of inputs to scan, 0..N_IN. Latched on an accepted start.
- slc  out  SEL_W  mux select (current index).
- out_valid  out  1  the mux output selected by `slc` is valid this cycle.
- out_ready  in  1  consumer accepts the current item.
- first  out  1  the current item is index 0 of this scan (only among enabled indices when masking).
- last  out  1  the current item is the final one of this scan.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse after the last transfer, or after an empty scan.
- en_mask  in  N_IN  per-input enable. Present only with MUX_SEQ_MASK_EN.

Behaviour:
- Reset: the FSM goes to IDLE, and `slc`=0, `out_valid`=0, `first`=0, `last`=0, `busy`=0, `done`=0.
- Reset wins over every other input. Reset during SCAN abandons the scan with no `done` pulse.
- States are IDLE, SCAN and DONE.
- IDLE:
  - `start`=1 latches `count` into `cnt_q` and sets `idx`=first enabled index.
  - If `count`=0, go to DONE (empty scan). Otherwise go to SCAN.
  - `count`>N_IN is clamped to N_IN.
- SCAN:
  - `out_valid`=1 and `slc`=`idx`.
  - A transfer is `out_valid` & `out_ready`.
  - On a transfer with `last`=0, `idx` advances to the next index (next enabled index when masking).
  - On a transfer with `last`=1, go to DONE.
  - Without a transfer, `slc`, `first` and `last` hold stable. `out_valid` never drops before its transfer.
- `last` = (`idx` == `cnt_q`-1), or, when masking, no enabled index exists in (`idx`, `cnt_q`-1].
- DONE: `done`=1 for exactly one cycle and `out_valid`=0, then go to IDLE.
- `start` while `busy` is ignored, not queued.
- Latency:
  - First `out_valid` appears in the cycle after `start`.
  - Full-rate throughput is one item per clock with `out_ready` held high.
  - `done` appears in the cycle after the last transfer.
- A scan of count=K with `out_ready`=1 takes K+2 cycles from `start` to `done` inclusive.
- `slc` returns to 0 in IDLE.
- Wrap-around: `idx` never exceeds `cnt_q`-1. For count=N_IN, the final index N_IN-1 is reached with no overflow.
- `count` and `en_mask` changes after `start` have no effect on the active scan.

Optional Feature:
- MUX_SEQ_MASK_EN defined:
  - The `en_mask` port exists and is latched on `start`.
  - Indices whose mask bit is 0 are skipped with zero bubble cycles, using a combinational next-enabled-index search.
  - If no enabled index lies within [0, `cnt_q`-1], the scan behaves as empty (IDLE→DONE).
- MUX_SEQ_MASK_EN undefined: there is no `en_mask` port, and every index 0..`cnt_q`-1 is visited in order.

Decomposition:
- Package mux_seq_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - the default N_IN, SEL_W and CNT_W constants;
  - a clog2-based width helper.
- Sub-module mux_seq_next_idx is a combinational priority search. Inputs are the mask, the current idx and the limit. Outputs are next_idx and has_next. It is instantiated only under MUX_SEQ_MASK_EN.

Test Plan:
- Reset, then `start` with count=4 and `out_ready`=1:
  - `slc` = 0,1,2,3 on consecutive cycles;
  - `first` at 0, `last` at 3;
  - `done` pulses in cycle 6 after `start`.
- count=64 with `out_ready` toggling 1,0,1,0:
  - every index 0..63 is transferred exactly once;
  - `slc`/`last` are stable while `out_ready`=0;
  - `done` appears once.
- count=0 → no `out_valid`; `done` 2 cycles after `start`. A second `start` during SCAN with count=8 is ignored.
- `rst` asserted at `slc`=5 of a count=10 scan → all outputs are 0 the next cycle, with no `done`. A new `start` scans from 0.
- MUX_SEQ_MASK_EN with `en_mask`=0x...0000_00A5 and count=8 → `slc` = 0,2,5,7; `first` at 0, `last` at 7.
- MUX_SEQ_MASK_EN with `en_mask`=0 and count=16 → empty scan, `done` only.
